// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a linear chain of DEPTH valid/data stages with
// load-use stall (hold young stages and insert a bubble), flush (kill the
// youngest stages), and output back-pressure (freeze the whole chain).
// Exactly one mode applies per cycle: freeze > flush > stall > advance.
module pipe_stage_chain #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 5,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic                         stall_req,
  input  logic                         flush_req,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  stall_cycles
);

  localparam int OCC_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_e;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [OCC_W-1:0] occ;
  logic             freeze;
  mode_e            mode;

  // A valid item at the output end that the consumer refuses stops everything;
  // an empty output stage never blocks.
  assign freeze = valid_q[DEPTH-1] & ~out_ready;

  // Priority select of the single mode that applies this cycle.
  always_comb begin
    if (freeze)         mode = MODE_FREEZE;
    else if (flush_req) mode = MODE_FLUSH;
    else if (stall_req) mode = MODE_STALL;
    else                mode = MODE_ADVANCE;
  end

  // Next-state of every stage for the selected mode; invalid stages carry 0.
  always_comb begin
    // NOTE: every stage defaults to "hold" before the case, so no branch can
    // leave a signal unassigned and infer a latch.
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];

    unique case (mode)
      MODE_FREEZE: begin
        if (flush_req) begin
          for (int i = 0; i < FLUSH_DEPTH; i++) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
          end
        end
      end
      MODE_FLUSH: begin
        for (int i = 1; i < DEPTH; i++) begin
          if (i >= FLUSH_DEPTH) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
          end
        end
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          valid_d[i] = 1'b0;
          data_d[i]  = '0;
        end
      end
      MODE_STALL: begin
        // Stages 0..STALL_STAGE keep their defaults (hold).
        for (int i = 1; i < DEPTH; i++) begin
          if (i == STALL_STAGE + 1) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
          end else if (i > STALL_STAGE + 1) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
          end
        end
      end
      default: begin
        for (int i = 1; i < DEPTH; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : '0;
      end
    endcase
  end

  // Saturating count of cycles in which stall mode was actually applied.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mode == MODE_STALL && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stage and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      // NOTE: the data registers are cleared on reset too, because an invalid
      // stage must read back as 0 and out_data must be 0 straight after reset.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // value of its neighbour, regardless of statement order.
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  // Population count of the valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  assign in_ready     = ~freeze & ~flush_req & ~stall_req;
  assign out_valid    = valid_q[DEPTH-1];
  assign out_data     = data_q[DEPTH-1];
  assign stage_valid  = valid_q;
  assign occupancy    = occ;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (DEPTH=5, WIDTH=32, STALL_STAGE=1,
// FLUSH_DEPTH=2). The reference model keeps the pipe as a list of slots and
// rebuilds that list each cycle by shifting, inserting bubbles and dropping.
module tb_pipe_stage_chain;

  localparam int WIDTH       = 32;
  localparam int DEPTH       = 5;
  localparam int STALL_STAGE = 1;
  localparam int FLUSH_DEPTH = 2;
  localparam int OCC_W       = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_ready;
  logic              stall_req = 1'b0;
  logic              flush_req = 1'b0;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready = 1'b1;
  logic [DEPTH-1:0]  stage_valid;
  logic [OCC_W-1:0]  occupancy;
  logic [15:0]       stall_cycles;

  int total = 0;
  int bad   = 0;

  pipe_stage_chain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_STAGE(STALL_STAGE), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stage_valid(stage_valid), .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } slot_t;

  slot_t model [DEPTH];
  int    model_stalls;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model_stalls = 0;
  endfunction

  function automatic void model_step(input logic iv, input logic [WIDTH-1:0] id,
                                     input logic sr, input logic fr, input logic ordy);
    slot_t nq[$];
    slot_t bubble;
    bubble = '0;
    if (model[DEPTH-1].v && !ordy) begin
      // output refused: nothing moves, flush may still kill the young end
      for (int i = 0; i < DEPTH; i++)
        nq.push_back((fr && i < FLUSH_DEPTH) ? bubble : model[i]);
    end else if (fr) begin
      repeat (FLUSH_DEPTH) nq.push_back(bubble);
      for (int i = FLUSH_DEPTH - 1; i < DEPTH - 1; i++) nq.push_back(model[i]);
    end else if (sr) begin
      for (int i = 0; i <= STALL_STAGE; i++) nq.push_back(model[i]);
      nq.push_back(bubble);
      for (int i = STALL_STAGE + 1; i < DEPTH - 1; i++) nq.push_back(model[i]);
      if (model_stalls < 65535) model_stalls++;
    end else begin
      nq.push_back(slot_t'{v: iv, d: (iv ? id : '0)});
      for (int i = 0; i < DEPTH - 1; i++) nq.push_back(model[i]);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = nq[i];
  endfunction

  function automatic logic [DEPTH-1:0] exp_valid();
    logic [DEPTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i] = model[i].v;
    return r;
  endfunction

  function automatic int exp_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (model[i].v) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  // Called just after a falling edge: drive, sample in_ready, clock once,
  // return just after the next falling edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic sr,
                      input logic fr, input logic ordy,
                      output logic rdy_seen, output logic rdy_exp);
    in_valid  = iv;
    in_data   = id;
    stall_req = sr;
    flush_req = fr;
    out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = !(model[DEPTH-1].v && !ordy) && !fr && !sr;
    model_step(iv, id, sr, fr, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = 1'b0;
    flush_req = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leaves S0..S4 = 5,4,3,2,1.
  task automatic fill_54321();
    logic rs, re;
    do_reset();
    for (int v = 1; v <= 5; v++) step(1'b1, WIDTH'(v), 1'b0, 1'b0, 1'b1, rs, re);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    total++; if (stage_valid !== '0) begin bad++; $display("FAIL reset_stage_valid got=%b exp=%b", stage_valid, 5'b0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    reset = 1'b1;
    model_clear();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic rs, re;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, WIDTH'(32'h10 + k), 1'b0, 1'b0, 1'b1, rs, re);
      total++; if (rs !== re) begin bad++; $display("FAIL stream_in_ready k=%0d got=%b exp=%b", k, rs, re); end
      total++; if (out_data !== model[DEPTH-1].d) begin bad++; $display("FAIL stream_out_data k=%0d got=%h exp=%h", k, out_data, model[DEPTH-1].d); end
      total++; if (stage_valid !== exp_valid()) begin bad++; $display("FAIL stream_stage_valid k=%0d got=%b exp=%b", k, stage_valid, exp_valid()); end
      if (k == 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_out_valid got=%b exp=0", out_valid); end
      end
      if (k >= 4) begin
        total++; if (out_data !== WIDTH'(32'h10 + k - 4)) begin bad++; $display("FAIL stream_latency k=%0d got=%h exp=%h", k, out_data, 32'h10 + k - 4); end
        total++; if (occupancy !== OCC_W'(5)) begin bad++; $display("FAIL stream_occupancy k=%0d got=%0d exp=5", k, occupancy); end
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, rs, re);
      total++; if (out_data !== model[DEPTH-1].d || out_valid !== model[DEPTH-1].v) begin bad++; $display("FAIL stream_drain k=%0d got=%b/%h exp=%b/%h", k, out_valid, out_data, model[DEPTH-1].v, model[DEPTH-1].d); end
    end
  endtask

  task automatic test_stall();
    logic rs, re;
    fill_54321();
    step(1'b1, WIDTH'(32'h99), 1'b1, 1'b0, 1'b1, rs, re);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", rs); end
    total++; if (stage_valid !== 5'b11011) begin bad++; $display("FAIL stall_stage_valid got=%b exp=11011", stage_valid); end
    total++; if (out_data !== WIDTH'(2)) begin bad++; $display("FAIL stall_out_data got=%h exp=2", out_data); end
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", stall_cycles); end
    total++; if (occupancy !== OCC_W'(4)) begin bad++; $display("FAIL stall_occupancy got=%0d exp=4", occupancy); end
    // drain: expect 3, bubble, 4, 5 in that order
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, rs, re);
      total++; if (out_valid !== model[DEPTH-1].v || out_data !== model[DEPTH-1].d) begin bad++; $display("FAIL stall_drain k=%0d got=%b/%h exp=%b/%h", k, out_valid, out_data, model[DEPTH-1].v, model[DEPTH-1].d); end
    end
  endtask

  task automatic test_flush_stall();
    logic rs, re;
    fill_54321();
    step(1'b1, WIDTH'(32'h99), 1'b1, 1'b1, 1'b1, rs, re);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", rs); end
    total++; if (stage_valid !== 5'b11100) begin bad++; $display("FAIL flush_stage_valid got=%b exp=11100", stage_valid); end
    total++; if (out_data !== WIDTH'(2)) begin bad++; $display("FAIL flush_out_data got=%h exp=2", out_data); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL flush_stall_count got=%0d exp=0", stall_cycles); end
    total++; if (occupancy !== OCC_W'(3)) begin bad++; $display("FAIL flush_occupancy got=%0d exp=3", occupancy); end
  endtask

  task automatic test_freeze();
    logic rs, re;
    fill_54321();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, rs, re);
    total++; if (out_data !== WIDTH'(1) || occupancy !== OCC_W'(5)) begin bad++; $display("FAIL freeze_c1 got=%h/%0d exp=1/5", out_data, occupancy); end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, rs, re);
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL freeze_in_ready got=%b exp=0", rs); end
    total++; if (out_data !== WIDTH'(1)) begin bad++; $display("FAIL freeze_c2_out_data got=%h exp=1", out_data); end
    total++; if (stage_valid !== 5'b11100 || occupancy !== OCC_W'(3)) begin bad++; $display("FAIL freeze_c2_kill got=%b/%0d exp=11100/3", stage_valid, occupancy); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, rs, re);
    total++; if (out_data !== WIDTH'(1) || occupancy !== OCC_W'(3)) begin bad++; $display("FAIL freeze_c3 got=%h/%0d exp=1/3", out_data, occupancy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL freeze_stall_count got=%0d exp=0", stall_cycles); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rs, re);
    total++; if (out_data !== WIDTH'(2)) begin bad++; $display("FAIL freeze_release1 got=%h exp=2", out_data); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rs, re);
    total++; if (out_data !== WIDTH'(3)) begin bad++; $display("FAIL freeze_release2 got=%h exp=3", out_data); end
  endtask

  task automatic test_random();
    logic rs, re;
    logic iv, sr, fr, ordy;
    logic [WIDTH-1:0] id;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      iv   = ($urandom % 4) != 0;
      id   = $urandom;
      sr   = ($urandom % 6) == 0;
      fr   = ($urandom % 12) == 0;
      ordy = ($urandom % 4) != 0;
      step(iv, id, sr, fr, ordy, rs, re);
      total++; if (rs !== re) begin bad++; $display("FAIL rand_in_ready k=%0d got=%b exp=%b", k, rs, re); end
      total++; if (stage_valid !== exp_valid()) begin bad++; $display("FAIL rand_stage_valid k=%0d got=%b exp=%b", k, stage_valid, exp_valid()); end
      total++; if (out_valid !== model[DEPTH-1].v || out_data !== model[DEPTH-1].d) begin bad++; $display("FAIL rand_out k=%0d got=%b/%h exp=%b/%h", k, out_valid, out_data, model[DEPTH-1].v, model[DEPTH-1].d); end
      total++; if (occupancy !== OCC_W'(exp_occ())) begin bad++; $display("FAIL rand_occupancy k=%0d got=%0d exp=%0d", k, occupancy, exp_occ()); end
      total++; if (stall_cycles !== 16'(model_stalls)) begin bad++; $display("FAIL rand_stall_count k=%0d got=%0d exp=%0d", k, stall_cycles, model_stalls); end
    end
  endtask

  task automatic test_mid_reset();
    logic rs, re;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, WIDTH'(32'hA0 + k), (k == 3), 1'b0, 1'b1, rs, re);
    total++; if (occupancy === '0 || stall_cycles !== 16'd1) begin bad++; $display("FAIL midreset_pre got=%0d/%0d exp=nonzero/1", occupancy, stall_cycles); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (stage_valid !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b/%b exp=0/0", stage_valid, out_valid); end
    total++; if (out_data !== '0 || occupancy !== '0) begin bad++; $display("FAIL midreset_data got=%h/%0d exp=0/0", out_data, occupancy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL midreset_stall_count got=%0d exp=0", stall_cycles); end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, rs, re);
    total++; if (stage_valid !== '0 || rs !== 1'b1) begin bad++; $display("FAIL midreset_after got=%b/%b exp=00000/1", stage_valid, rs); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush_req = 1'b0;
    stall_req = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    total++; if (stall_cycles !== 16'd100) begin bad++; $display("FAIL sat_partial got=%0d exp=100", stall_cycles); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sat_in_ready got=%b exp=0", in_ready); end
    repeat (65440) @(posedge clk);
    @(negedge clk);
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_reached got=%h exp=ffff", stall_cycles); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
    stall_req = 1'b0;
    do_reset();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_freeze();
    test_random();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
